// File: rtl/cim_pkg.sv
// Shared constants and state encoding for the CiM accumulator controller.
package cim_pkg;

  localparam int unsigned ACC_W_DEF     = 32;
  localparam int unsigned SEG_W_DEF     = 8;
  localparam int unsigned OUT_DEPTH_DEF = 2;

  localparam logic ST_ACC = 1'b0;
  localparam logic ST_CAP = 1'b1;

  typedef enum logic {
    StAcc = ST_ACC,
    StCap = ST_CAP
  } acc_state_e;

endpackage

// File: rtl/acc_res_fifo.sv
// Synchronous result FIFO; head entry is shown on o_data, zero while empty.
module acc_res_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PtrW'(1);
      if (i_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_cnt <= r_cnt + CntW'(i_push) - CntW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CntW'(Depth));
  assign o_count = r_cnt;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/acc_ctrl.sv
// Sequences adder-tree beats into grouped accumulations and queues each finished sum
// for downstream consumption.
module acc_ctrl
  import cim_pkg::*;
#(
  parameter int unsigned SEG_W     = SEG_W_DEF,
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic [SEG_W-1:0] cfg_num_seg_i,
  input  logic             soft_clr_i,
  input  logic             tree_valid_i,
  output logic             tree_ready_o,
  output logic             acc_dff_en_o,
  output logic             oprand_sel_o,
  input  logic [ACC_W-1:0] acc_out_i,
  output logic [ACC_W-1:0] res_data_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

  acc_state_e       r_state;
  logic [SEG_W-1:0] r_seg_cnt;
  logic [SEG_W-1:0] r_seg_tgt;

  logic [SEG_W-1:0] w_tgt;
  logic [CntW-1:0]  w_fifo_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    // Group length is sampled only on the first beat; mid-group cfg changes are ignored.
    w_tgt = r_seg_tgt;
    if (r_seg_cnt == '0) begin
      w_tgt = (cfg_num_seg_i == '0) ? SEG_W'(1) : cfg_num_seg_i;
    end
    w_ready  = (r_state == StAcc) && (w_fifo_cnt < CntW'(OUT_DEPTH)) && !soft_clr_i;
    w_accept = tree_valid_i && w_ready;
    w_last   = ((r_seg_cnt + SEG_W'(1)) == w_tgt);
    w_push   = (r_state == StCap) && !soft_clr_i;
    w_pop    = res_ready_i && !w_empty;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= StAcc;
      r_seg_cnt <= '0;
      r_seg_tgt <= '0;
    end else if (soft_clr_i) begin
      r_state   <= StAcc;
      r_seg_cnt <= '0;
    end else begin
      case (r_state)
        StAcc: begin
          if (w_accept) begin
            r_seg_tgt <= w_tgt;
            if (w_last) begin
              r_seg_cnt <= '0;
              r_state   <= StCap;
            end else begin
              r_seg_cnt <= r_seg_cnt + SEG_W'(1);
            end
          end
        end
        StCap:   r_state <= StAcc;
        default: r_state <= StAcc;
      endcase
    end
  end

  acc_res_fifo #(
    .Width(ACC_W),
    .Depth(OUT_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n_i(rst_n_i),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (acc_out_i),
    .o_data (res_data_o),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_fifo_cnt)
  );

  assign tree_ready_o = w_ready;
  assign acc_dff_en_o = w_accept;
  assign oprand_sel_o = (r_seg_cnt != '0);
  assign res_valid_o  = !w_empty;
  assign busy_o       = (r_seg_cnt != '0) || (r_state == StCap) || !w_empty;

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl with a behavioural Accumulator, a group-level reference model and a
// result scoreboard.
module tb_acc_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 8;
  localparam int          OD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] cfg_num_seg;
  logic          soft_clr;
  logic          tree_valid;
  logic          tree_ready;
  logic          acc_dff_en;
  logic          oprand_sel;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic [15:0]   tree_data;

  int            n_checks = 0;
  int            n_err = 0;

  // Reference model state: beats in current group, group length, pending/queued results.
  int            m_n = 0;
  int            m_tgt = 1;
  int            m_occ = 0;
  bit            m_cap = 1'b0;
  logic [31:0]   m_sum = '0;
  logic [31:0]   m_pend = '0;
  logic [31:0]   exp_q[$];
  bit            rnd_done = 1'b0;

  always #5 clk = ~clk;

  acc_ctrl #(
    .SEG_W    (SW),
    .OUT_DEPTH(OD),
    .ACC_W    (AW)
  ) dut (
    .clk          (clk),
    .rst_n_i      (rst_n),
    .cfg_num_seg_i(cfg_num_seg),
    .soft_clr_i   (soft_clr),
    .tree_valid_i (tree_valid),
    .tree_ready_o (tree_ready),
    .acc_dff_en_o (acc_dff_en),
    .oprand_sel_o (oprand_sel),
    .acc_out_i    (acc_q),
    .res_data_o   (res_data),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .busy_o       (busy)
  );

  function automatic logic [31:0] sext(input logic [15:0] d);
    return {{16{d[15]}}, d};
  endfunction

  // Behavioural Accumulator: sign-extended tree beat, load or add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else if (acc_dff_en) acc_q <= oprand_sel ? acc_q + sext(tree_data) : sext(tree_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated once per cycle away from the clock edge.
  always @(negedge clk) begin
    bit exp_rdy, acc, nxt_cap, push, pop;
    if (rst_n) begin
      exp_rdy = !m_cap && (m_occ < OD) && !soft_clr;
      acc     = tree_valid && exp_rdy;
      nxt_cap = 1'b0;
      chk("tree_ready", 32'(tree_ready), 32'(exp_rdy));
      chk("acc_dff_en", 32'(acc_dff_en), 32'(acc));
      chk("oprand_sel", 32'(oprand_sel), 32'(m_n != 0));
      chk("res_valid", 32'(res_valid), 32'(m_occ > 0));
      chk("busy", 32'(busy), 32'((m_n != 0) || m_cap || (m_occ > 0)));
      if (acc) begin
        if (m_n == 0) begin
          m_tgt = (cfg_num_seg == 0) ? 1 : int'(cfg_num_seg);
          m_sum = '0;
        end
        m_sum = m_sum + sext(tree_data);
        m_n++;
        if (m_n == m_tgt) begin
          m_n     = 0;
          nxt_cap = 1'b1;
        end
      end
      pop  = (m_occ > 0) && res_ready;
      push = m_cap && !soft_clr;
      if (push) exp_q.push_back(m_pend);
      m_occ = m_occ + int'(push) - int'(pop);
      if (nxt_cap) m_pend = m_sum;
      m_cap = nxt_cap;
      if (soft_clr) m_n = 0;
    end
  end

  // Scoreboard monitor: compares every popped result against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", res_data, 32'hxxxx_xxxx);
        end else begin
          chk("res_data", res_data, exp_q.pop_front());
        end
      end else if (!res_valid) begin
        chk("res_data_empty", res_data, '0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    tree_valid = 1'b1;
    tree_data  = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = tree_ready;
      @(posedge clk);
      #1;
      n++;
    end
    tree_valid = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic clr_pulse(input bit with_beat, input logic [15:0] d);
    tree_valid = with_beat;
    tree_data  = d;
    soft_clr   = 1'b1;
    @(posedge clk);
    #1;
    soft_clr   = 1'b0;
    tree_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_n   = 0;
    m_cap = 1'b0;
    m_occ = 0;
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_num_seg = '0;
    soft_clr    = 1'b0;
    tree_valid  = 1'b0;
    tree_data   = '0;
    res_ready   = 1'b1;
    rst_n       = 1'b0;
    @(negedge clk);
    chk("rst_tree_ready", 32'(tree_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_data", res_data, '0);
    chk("rst_acc_en", 32'(acc_dff_en), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Group of 4: 3 - 1 + 10 + 5 = 17.
    cfg_num_seg = 8'd4;
    send(16'd3);
    send(16'hFFFF);
    send(16'd10);
    send(16'd5);
    idle(3);

    // Single-beat groups with sign extension.
    cfg_num_seg = 8'd1;
    send(16'h8000);
    send(16'h7FFF);
    idle(3);

    // Fill the FIFO with downstream stalled, then release one slot.
    res_ready   = 1'b0;
    cfg_num_seg = 8'd2;
    repeat (4) send(16'd1);
    idle(2);
    fork
      begin
        send(16'd1);
        send(16'd1);
      end
      begin
        idle(6);
        res_ready = 1'b1;
        idle(1);
        res_ready = 1'b0;
      end
    join
    idle(3);
    res_ready = 1'b1;
    idle(5);

    // Soft clear mid-group, with a beat offered during the clear.
    cfg_num_seg = 8'd3;
    send(16'd1);
    send(16'd2);
    clr_pulse(1'b1, 16'd99);
    send(16'd7);
    send(16'd8);
    send(16'd9);
    idle(3);

    // cfg=0 behaves as 1; cfg change mid-group ignored.
    cfg_num_seg = 8'd0;
    send(16'd42);
    cfg_num_seg = 8'd2;
    send(16'd5);
    cfg_num_seg = 8'd5;
    send(16'd6);
    idle(3);

    // Async reset while in CAP with one result queued.
    res_ready   = 1'b0;
    cfg_num_seg = 8'd1;
    send(16'd3);
    idle(2);
    send(16'd4);
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_tree_ready", 32'(tree_ready), 32'd1);
    @(posedge clk);
    #1 res_ready = 1'b1;

    // Randomized traffic with random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int r;
          r = int'($urandom_range(0, 9));
          if (r < 7) begin
            if ($urandom_range(0, 3) == 0) cfg_num_seg = 8'($urandom_range(0, 5));
            send(16'($urandom));
          end else if (r < 8) begin
            clr_pulse(1'($urandom_range(0, 1)), 16'($urandom));
          end else begin
            idle(int'($urandom_range(1, 3)));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    tree_valid = 1'b0;
    res_ready  = 1'b1;
    idle(10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
